// File: rtl/regfile_dumper.sv
// Streams a contiguous (optionally wrapping) range of register-file words out over a
// valid/ready interface, one word per fetch/send pair, with a running XOR checksum.
module regfile_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] first_reg_i,
  input  logic [ADDR_WIDTH-1:0] last_reg_i,
  output logic [ADDR_WIDTH-1:0] read_register_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   last_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [ADDR_WIDTH-1:0]   out_addr_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   checksum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Abort is meaningless here, so a simultaneous Start is simply accepted.
          if (start_i) begin
            ptr_q      <= first_reg_i;
            last_q     <= last_reg_i;
            checksum_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            out_data_q  <= read_data_i;
            out_addr_q  <= ptr_q;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          // Abort beats a handshake on the same edge: the word is dropped, not counted.
          if (abort_i) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (out_ready_i) begin
            checksum_q  <= checksum_q ^ out_data_q;
            out_valid_q <= 1'b0;
            if (ptr_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ptr_q   <= ptr_q + 1'b1;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign read_register_o = ptr_q;
  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign out_addr_o      = out_addr_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign checksum_o      = checksum_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: table-driven dumps, hand-written corner sequences and
// randomized dumps scored against an address-sequence / XOR reference model.
module tb_regfile_dumper;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW-1:0] last_reg = '0;
  logic [AW-1:0] read_reg;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] read_data;
  logic [DW-1:0] out_data;
  logic [DW-1:0] checksum;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [NREG];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign read_data = regs[read_reg];

  regfile_dumper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .first_reg_i(first_reg), .last_reg_i(last_reg),
    .read_register_o(read_reg), .read_data_i(read_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_addr_o(out_addr),
    .busy_o(busy), .done_o(done), .checksum_o(checksum)
  );

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One dump: the model lists the addresses the range must visit, then every
  // transferred word is matched against that list and the register contents.
  task automatic do_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                         input int ready_pct, input int abort_idx, input bit spurious,
                         output int got_n, output logic [DW-1:0] got_cs);
    int exp_addr[$];
    int a, idx, cyc;
    logic [DW-1:0] cs;
    bit hs, ab, first_seen;
    exp_addr.delete();
    a = int'(f);
    exp_addr.push_back(a);
    while (a != int'(l)) begin
      a = (a + 1) % NREG;
      exp_addr.push_back(a);
    end
    first_reg = f; last_reg = l; start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1; idx = 0; cs = '0; first_seen = 1'b0; got_n = -1; got_cs = '0;
    check("busy_after_start", busy, 1'b1);
    forever begin
      if (cyc > 2000) begin
        checks++; errors++;
        $display("FAIL dump_timeout got=%0d words exp=%0d words", idx, exp_addr.size());
        break;
      end
      if (out_valid) begin
        if (!first_seen) begin
          check("first_latency", cyc, 2);
          first_seen = 1'b1;
        end
        if (idx < exp_addr.size()) begin
          check("out_addr", out_addr, exp_addr[idx]);
          check("out_data", out_data, regs[exp_addr[idx]]);
        end else begin
          checks++; errors++;
          $display("FAIL extra_word got=%0d words exp=%0d words", idx + 1, exp_addr.size());
        end
      end
      if (done) begin
        check("done_word_count", idx, exp_addr.size());
        check("checksum_at_done", checksum, cs);
        got_n = idx; got_cs = checksum;
        tick();
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("checksum_hold", checksum, cs);
        break;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      ab = out_valid && (idx == abort_idx);
      abort = ab;
      if (spurious) begin
        start = 1'($urandom_range(1));
        first_reg = AW'($urandom);
        last_reg = AW'($urandom);
      end
      hs = out_valid && out_ready && !ab;
      tick();
      cyc++;
      start = 1'b0;
      if (ab) begin
        abort = 1'b0; out_ready = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", out_valid, 1'b0);
        check("abort_no_done", done, 1'b0);
        check("abort_checksum", checksum, cs);
        got_n = idx; got_cs = checksum;
        break;
      end
      if (hs) begin
        if (idx < exp_addr.size()) cs ^= regs[exp_addr[idx]];
        idx++;
        check("no_back_to_back", out_valid, 1'b0);
      end
    end
    out_ready = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    int            n_words;
    logic [DW-1:0] exp_cs;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n;
    logic [DW-1:0] cs, saved, saved11;

    for (int i = 0; i < NREG; i++) regs[i] = 32'h1000 + i * 3;
    regs[0] = 0; regs[1] = 32'h44; regs[2] = 42; regs[3] = 15;
    regs[5] = 32'h55; regs[30] = 32'h11; regs[31] = 32'h22;

    tbl[0] = '{first: 5'd2,  last: 5'd3,  n_words: 2, exp_cs: 32'd37};
    tbl[1] = '{first: 5'd30, last: 5'd1,  n_words: 4, exp_cs: 32'h77};
    tbl[2] = '{first: 5'd5,  last: 5'd5,  n_words: 1, exp_cs: 32'h55};
    tbl[3] = '{first: 5'd31, last: 5'd0,  n_words: 2, exp_cs: 32'h22};
    tbl[4] = '{first: 5'd0,  last: 5'd1,  n_words: 2, exp_cs: 32'h44};

    // Reset state, observed before any clock edge
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_addr", out_addr, '0);
    check("rst_checksum", checksum, '0);
    check("rst_read_reg", read_reg, '0);
    #10 rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      do_dump(tbl[i].first, tbl[i].last, 100, -1, 1'b0, n, cs);
      check("tbl_words", n, tbl[i].n_words);
      check("tbl_checksum", cs, tbl[i].exp_cs);
    end

    // Back-pressure: word held stable, ReadData ignored outside FETCH
    regs[10] = 32'hA5A5_0010; regs[11] = 32'h0F0F_0011;
    first_reg = 10; last_reg = 11; start = 1'b1; out_ready = 1'b0;
    tick(); start = 1'b0; tick();
    check("stall_valid", out_valid, 1'b1);
    check("stall_first_data", out_data, 32'hA5A5_0010);
    saved = regs[10]; saved11 = regs[11];
    regs[10] = ~saved;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_hold_valid", out_valid, 1'b1);
      check("stall_hold_addr", out_addr, 5'd10);
      check("stall_hold_data", out_data, saved);
      check("stall_ptr", read_reg, 5'd10);
    end
    out_ready = 1'b1;
    tick();
    check("stall_release_valid", out_valid, 1'b0);
    check("stall_ptr_adv", read_reg, 5'd11);
    check("stall_checksum", checksum, saved);
    for (int k = 0; k < 10 && !done; k++) tick();
    check("stall_done", done, 1'b1);
    check("stall_final_cs", checksum, saved ^ saved11);
    out_ready = 1'b0; regs[10] = saved;
    tick();

    // Abort in second SEND of a 4-word dump
    do_dump(5'd8, 5'd11, 100, 1, 1'b0, n, cs);
    check("abort_words", n, 1);
    check("abort_cs_first_only", cs, regs[8]);

    // Start+Abort in IDLE: Start wins; Abort in FETCH returns to IDLE
    first_reg = 4; last_reg = 6; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0;
    check("idle_start_wins", busy, 1'b1);
    tick();
    abort = 1'b0;
    check("fetch_abort_busy", busy, 1'b0);
    check("fetch_abort_valid", out_valid, 1'b0);
    tick();

    // Start during Busy ignored, then asynchronous reset mid-dump
    first_reg = 0; last_reg = 20; start = 1'b1; out_ready = 1'b0;
    tick(); start = 1'b0; tick(); tick();
    first_reg = 7; last_reg = 9; start = 1'b1;
    tick(); start = 1'b0;
    check("busy_start_ignored", out_addr, 5'd0);
    out_ready = 1'b1;
    tick(); tick();
    check("range_unaltered", out_addr, 5'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_data", out_data, '0);
    check("async_rst_addr", out_addr, '0);
    check("async_rst_cs", checksum, '0);
    check("async_rst_ptr", read_reg, '0);
    #3 rst_n = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_idle", busy, 1'b0);
      check("post_rst_valid", out_valid, 1'b0);
    end
    do_dump(5'd5, 5'd5, 100, -1, 1'b0, n, cs);
    check("post_rst_words", n, 1);
    check("post_rst_cs", cs, 32'h55);

    // Randomized dumps
    for (int t = 0; t < 25; t++) begin
      int pct, abi;
      for (int i = 0; i < NREG; i++) regs[i] = $urandom;
      pct = $urandom_range(30, 100);
      abi = ($urandom_range(3) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_dump(AW'($urandom), AW'($urandom), pct, abi, 1'b1, n, cs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register word width.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width (32 registers).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Clk  in  1  clock; all state changes on the positive edge.
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 Start  in  1  single-cycle request to begin a dump; sampled only in IDLE.
REQ-007 Abort  in  1  synchronous cancel of a dump in progress.
REQ-008 FirstReg  in  ADDR_WIDTH  first register to dump; latched on an accepted Start.
REQ-009 LastReg  in  ADDR_WIDTH  last register to dump; latched on an accepted Start.
REQ-010 ReadRegister  out  ADDR_WIDTH  address driven to a register-file asynchronous read port.
REQ-011 ReadData  in  DATA_WIDTH  combinational read data returned for ReadRegister.
REQ-012 OutValid  out  1  OutData/OutAddr hold a valid word.
REQ-013 OutReady  in  1  downstream sink accepts the word.
REQ-014 OutData  out  DATA_WIDTH  captured register contents.
REQ-015 OutAddr  out  ADDR_WIDTH  register number of OutData.
REQ-016 Busy  out  1  high in every state except IDLE.
REQ-017 Done  out  1  one-cycle pulse when the last word has been accepted.
REQ-018 Checksum  out  DATA_WIDTH  running XOR of all accepted words in the current dump.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, SEND, DONE.
REQ-020 IDLE with Start=1: latch FirstReg/LastReg, set ptr=FirstReg, clear Checksum to 0, go to FETCH.
REQ-021 ReadRegister SHALL equal ptr in all states; the value is undefined-for-use outside FETCH.
REQ-022 FETCH: on the next edge, OutData<=ReadData, OutAddr<=ptr, go to SEND; the latency from Start to first OutValid SHALL be 2 cycles.
REQ-023 SEND: OutValid=1; OutData and OutAddr SHALL remain stable while OutReady=0.
REQ-024 Handshake occurs on an edge where OutValid=1 and OutReady=1; Checksum<=Checksum XOR OutData.
REQ-025 On handshake with ptr==last: go to DONE; otherwise ptr<=(ptr+1) mod 32 and go to FETCH.
REQ-026 The word rate SHALL be at most 1 word per 2 cycles; there are no back-to-back valid cycles.
REQ-027 Wrap-around: if FirstReg>LastReg, the sequence SHALL run FirstReg..31, 0..LastReg.
REQ-028 FirstReg==LastReg SHALL dump exactly one word.
REQ-029 DONE: Done=1 for exactly one cycle, then IDLE; Checksum holds its final value until the next accepted Start.
REQ-030 Start while Busy=1 SHALL be ignored and SHALL NOT alter the latched range.
REQ-031 Abort=1 in FETCH/SEND/DONE: go to IDLE next edge, OutValid=0, no Done pulse, Checksum retains its partial value; Abort has priority over handshake on the same edge.
REQ-032 Abort together with Start in IDLE: Start SHALL win (Abort has no effect in IDLE).
REQ-033 ReadData SHALL be sampled only in FETCH; changes at other times SHALL have no effect.

Reset
REQ-034 Reset_n=0 SHALL immediately force IDLE, ptr=0, OutValid=0, OutData=0, OutAddr=0, Busy=0, Done=0, Checksum=0, independent of Clk.
REQ-035 Reset asserted mid-dump SHALL discard the dump; after release, the block SHALL wait in IDLE for a new Start.

Verification
REQ-036 Regfile with reg2=42, reg3=15; Start, First=2, Last=3, OutReady=1 -> words (2,42),(3,15), OutValid at cycles +2 and +4, Done pulse, Checksum=42^15=37.
REQ-037 First=30, Last=1, OutReady=1 -> OutAddr sequence 30,31,0,1; reg0 reads 0; Done after 4 handshakes.
REQ-038 OutReady held 0 for 5 cycles in SEND -> OutValid stays 1, OutData/OutAddr unchanged, ptr does not advance; release -> one handshake.
REQ-039 Abort asserted in the second SEND of a 4-word dump -> IDLE next cycle, Busy=0, no Done, Checksum = first word only.
REQ-040 Reset_n pulsed low between clock edges mid-dump -> all outputs 0 immediately; a Start issued during the dump's Busy phase is ignored; a Start after recovery with First=5, Last=5 -> exactly one word (5, reg5).
